// File: rtl/kypd_pkg.sv
// Shared types and the keypad legend for the 4x4 hex keypad scanner.
package kypd_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kypd_state_t;

  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_res_t;

  // Indexed [row][column]; row 0 is the top row, column 0 the leftmost.
  localparam logic [3:0] KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'h0, 4'hF, 4'hE, 4'hD}
  };

  function automatic frame_res_t classify(input logic [1:0] low_cnt);
    case (low_cnt)
      2'd0:    return FR_NONE;
      2'd1:    return FR_SINGLE;
      default: return FR_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// Column scanner: one active-low column per 2^SCAN_N-cycle dwell, with sample and frame-end strobes.
module kypd_col_scan #(
  parameter int SCAN_N = 17
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col,
  output logic [1:0] col_idx,
  output logic       sample,
  output logic       frame_end
);

  logic [SCAN_N-1:0] dwell_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      dwell_cnt <= '0;
      col_idx   <= 2'd0;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
      if (sample) col_idx <= col_idx + 2'd1;
    end
  end

  // Rows are sampled on the last cycle of a dwell, once they have long settled.
  assign sample    = &dwell_cnt;
  assign frame_end = sample && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

endmodule

// File: rtl/kypd_scan_4digit.sv
// 4x4 keypad scanner with frame debounce and a 4-digit shift register for the display.
// Optional auto-repeat while a key is held: define KYPD_AUTOREPEAT_EN.
module kypd_scan_4digit #(
  parameter int SCAN_N          = 17,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int REPEAT_DELAY    = 250,
  parameter int REPEAT_RATE     = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  input  logic       clr,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3
);
  import kypd_pkg::*;

  if (DEBOUNCE_FRAMES < 1 || DEBOUNCE_FRAMES > 15 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("kypd_scan_4digit: parameter out of range");
  end

  localparam logic [3:0] DF = 4'(DEBOUNCE_FRAMES);

  logic [1:0]  col_idx;
  logic        sample, frame_end;
  logic [3:0]  row_meta, row_sync;
  logic [1:0]  acc_cnt, frame_cnt;
  logic [3:0]  acc_key, frame_key;
  frame_res_t  fr;
  kypd_state_t state, state_n;
  logic [3:0]  cand, cand_n, deb_cnt, cnt_n, deb_inc;
  logic        accept;

  kypd_col_scan #(.SCAN_N(SCAN_N)) u_col_scan (
    .clk      (clk),
    .reset    (reset),
    .col      (col),
    .col_idx  (col_idx),
    .sample   (sample),
    .frame_end(frame_end)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // Frame accumulator: low-row count saturates at 2 (= MULTI); the first low row found names the key.
  always_comb begin
    frame_cnt = (col_idx == 2'd0) ? 2'd0 : acc_cnt;
    frame_key = (col_idx == 2'd0) ? 4'h0 : acc_key;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        if (frame_cnt == 2'd0) frame_key = KEY_MAP[r][col_idx];
        if (frame_cnt != 2'd2) frame_cnt = frame_cnt + 2'd1;
      end
    end
  end

  assign fr = classify(frame_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_cnt <= 2'd0;
      acc_key <= 4'h0;
    end else if (sample) begin
      acc_cnt <= frame_cnt;
      acc_key <= frame_key;
    end
  end

`ifdef KYPD_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_DELAY + REPEAT_RATE + 1);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_DELAY + REPEAT_RATE);
  logic [REP_W-1:0] rep_cnt, rep_n, rep_inc;

  always_ff @(posedge clk) begin
    if (reset) rep_cnt <= '0;
    else       rep_cnt <= rep_n;
  end

  assign rep_inc = rep_cnt + 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cand    <= 4'h0;
      deb_cnt <= 4'd0;
    end else begin
      state   <= state_n;
      cand    <= cand_n;
      deb_cnt <= cnt_n;
    end
  end

  assign deb_inc = deb_cnt + 4'd1;

  // Debounce FSM; it only moves on frame-end strobes.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    cnt_n   = deb_cnt;
    accept  = 1'b0;
`ifdef KYPD_AUTOREPEAT_EN
    rep_n   = rep_cnt;
`endif
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (fr == FR_SINGLE) begin
            cand_n = frame_key;
            cnt_n  = 4'd1;
            if (DF == 4'd1) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end else begin
              state_n = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (fr == FR_SINGLE && frame_key == cand) begin
            cnt_n = deb_inc;
            if (deb_inc == DF) begin
              state_n = PRESSED;
              accept  = 1'b1;
            end
          end else if (fr == FR_SINGLE) begin
            cand_n = frame_key;
            cnt_n  = 4'd1;
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
          end
        end
        PRESSED: begin
          if (fr == FR_NONE) begin
            cnt_n = 4'd1;
            if (DF == 4'd1) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end else begin
              state_n = RELEASE;
            end
          end
`ifdef KYPD_AUTOREPEAT_EN
          else begin
            rep_n = rep_inc;
            if (rep_inc == REP_FIRST) begin
              accept = 1'b1;
            end else if (rep_inc == REP_NEXT) begin
              accept = 1'b1;
              rep_n  = REP_FIRST;
            end
          end
`endif
        end
        RELEASE: begin
          if (fr == FR_NONE) begin
            cnt_n = deb_inc;
            if (deb_inc == DF) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end
          end else begin
            state_n = PRESSED;
          end
        end
        default: state_n = IDLE;
      endcase
    end
`ifdef KYPD_AUTOREPEAT_EN
    if (state_n == IDLE) rep_n = '0;
`endif
  end

  // Clear beats a same-cycle accept for the digits, but the event and code still go out.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_valid <= 1'b0;
      key_code  <= 4'h0;
      dig0      <= 4'h0;
      dig1      <= 4'h0;
      dig2      <= 4'h0;
      dig3      <= 4'h0;
    end else begin
      key_valid <= accept;
      if (accept) key_code <= cand_n;
      if (clr) begin
        dig0 <= 4'h0;
        dig1 <= 4'h0;
        dig2 <= 4'h0;
        dig3 <= 4'h0;
      end else if (accept) begin
        dig3 <= dig2;
        dig2 <= dig1;
        dig1 <= dig0;
        dig0 <= cand_n;
      end
    end
  end

  assign key_held = (state == PRESSED) || (state == RELEASE);

endmodule

// File: tb/tb_kypd_scan_4digit.sv
// Self-checking bench for kypd_scan_4digit: keypad model, frame-level reference model, directed scenarios.
module tb_kypd_scan_4digit;

  localparam int SCAN_N = 4;
  localparam int DF     = 4;
  localparam int RD     = 3;
  localparam int RR     = 2;
  localparam int DWELL  = 16;
  localparam int FRAME  = 64;

  // Keypad legend by index row*4+col.
  localparam logic [3:0] KMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                       4'h4, 4'h5, 4'h6, 4'hB,
                                       4'h7, 4'h8, 4'h9, 4'hC,
                                       4'h0, 4'hF, 4'hE, 4'hD};

  logic       clk = 1'b0;
  logic       reset, clr;
  logic [3:0] row, col, key_code, dig0, dig1, dig2, dig3;
  logic       key_valid, key_held;
  logic [15:0] keys;

  int compared   = 0;
  int mismatched = 0;
  int dut_pulses = 0;
  int last_pulse_t = -1;

  always #5 clk = ~clk;

  kypd_scan_4digit #(
    .SCAN_N(SCAN_N), .DEBOUNCE_FRAMES(DF), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .reset(reset), .row(row), .clr(clr), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3)
  );

  // Passive keypad: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  // Reference model: frame classification by key count, debounce as run lengths of identical frames.
  int         mt;
  bit         model_ready = 1'b0;
  logic [3:0] e_col, e_code;
  logic [3:0] e_dig [4];
  logic       e_valid, e_held;
  int         run_kind, run_len, fr_n, fpress;
  logic [3:0] fr_key;
  bit         prev_had_key;

  task automatic doAccept(input logic [3:0] k);
    e_valid  = 1'b1;
    e_code   = k;
    e_dig[3] = e_dig[2];
    e_dig[2] = e_dig[1];
    e_dig[1] = e_dig[0];
    e_dig[0] = k;
  endtask

  task automatic frameDone();
    int kind;
    kind = (fr_n == 0) ? 16 : (fr_n == 1) ? int'(fr_key) : 17;
    if (kind == run_kind) run_len++;
    else begin
      run_kind = kind;
      run_len  = 1;
    end
    if (!e_held) begin
      if (kind < 16 && run_len == DF) begin
        doAccept(fr_key);
        e_held = 1'b1;
        fpress = 0;
      end
    end else if (kind == 16 && run_len == DF) begin
      e_held = 1'b0;
      fpress = 0;
    end
`ifdef KYPD_AUTOREPEAT_EN
    else if (kind != 16 && prev_had_key) begin
      fpress++;
      if (fpress == RD || (fpress > RD && (fpress - RD) % RR == 0)) doAccept(e_code);
    end
`endif
    prev_had_key = (kind != 16);
  endtask

  always @(posedge clk) begin
    int c;
    model_ready = 1'b1;
    if (reset) begin
      mt = 0; e_col = 4'b1110; e_valid = 1'b0; e_code = 4'h0; e_held = 1'b0;
      for (int i = 0; i < 4; i++) e_dig[i] = 4'h0;
      run_kind = 16; run_len = 0; fr_n = 0; fr_key = 4'h0; fpress = 0; prev_had_key = 1'b0;
    end else begin
      e_valid = 1'b0;
      if (mt % DWELL == DWELL - 1) begin
        c = (mt / DWELL) % 4;
        if (c == 0) fr_n = 0;
        for (int r = 0; r < 4; r++)
          if (keys[r*4+c]) begin
            if (fr_n == 0) fr_key = KMAP[r*4+c];
            fr_n++;
          end
        if (c == 3) frameDone();
      end
      mt++;
      e_col = ~(4'b0001 << ((mt / DWELL) % 4));
      if (clr) for (int i = 0; i < 4; i++) e_dig[i] = 4'h0;
    end
  end

  always @(negedge clk) begin
    if (model_ready) begin
      compared++;
      if ({col, key_valid, key_code, key_held, dig3, dig2, dig1, dig0} !==
          {e_col, e_valid, e_code, e_held, e_dig[3], e_dig[2], e_dig[1], e_dig[0]}) begin
        mismatched++;
        $display("[TB] FAIL cycle_outputs t=%0d: got col=%b valid=%b code=%h held=%b dig=%h%h%h%h, want col=%b valid=%b code=%h held=%b dig=%h%h%h%h",
                 mt, col, key_valid, key_code, key_held, dig3, dig2, dig1, dig0,
                 e_col, e_valid, e_code, e_held, e_dig[3], e_dig[2], e_dig[1], e_dig[0]);
      end
      if (key_valid === 1'b1) begin
        dut_pulses++;
        last_pulse_t = mt;
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic waitFrames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  task automatic waitFrameStart();
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (mt % FRAME == 0) return;
      @(negedge clk);
    end
    checkOutput("frame_align_timeout", mt % FRAME, 0);
  endtask

  // Holds the given key set from a frame boundary for a whole number of frames.
  task automatic applyStimulus(input logic [15:0] k, input int frames);
    waitFrameStart();
    keys = k;
    waitFrames(frames);
  endtask

  initial begin
    int base, t0;
    keys = 16'h0; clr = 1'b0; reset = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_col", col, 4'b1110);
    checkOutput("reset_valid", key_valid, 0);
    reset = 1'b0;

    // Idle scanning
    waitFrames(10);
    checkOutput("idle_pulses", dut_pulses, 0);
    checkOutput("idle_col_f10", col, 4'b1110);
    repeat (16) @(negedge clk);
    checkOutput("idle_col_next", col, 4'b1101);

    // Single press of "5"
    waitFrameStart();
    t0 = mt;
    applyStimulus(16'b1 << 5, 6);
    checkOutput("k5_pulses", dut_pulses, 1);
    checkOutput("k5_latency", last_pulse_t - t0, 4 * FRAME);
    checkOutput("k5_code", key_code, 4'h5);
    checkOutput("k5_dig0", dig0, 4'h5);
    applyStimulus(16'h0, 3);
    checkOutput("k5_held_3rel", key_held, 1);
    waitFrames(1);
    checkOutput("k5_held_4rel", key_held, 0);

    // Sequence 1 2 3 A 7
    base = dut_pulses;
    applyStimulus(16'b1 << 0, 5);  applyStimulus(16'h0, 5);
    applyStimulus(16'b1 << 1, 5);  applyStimulus(16'h0, 5);
    applyStimulus(16'b1 << 2, 5);  applyStimulus(16'h0, 5);
    applyStimulus(16'b1 << 3, 5);  applyStimulus(16'h0, 5);
    applyStimulus(16'b1 << 8, 5);  applyStimulus(16'h0, 5);
    checkOutput("seq_pulses", dut_pulses - base, 5);
    checkOutput("seq_digits", {dig3, dig2, dig1, dig0}, 16'h23A7);

    // Bouncing "9"
    base = dut_pulses;
    applyStimulus(16'b1 << 10, 2);
    applyStimulus(16'h0, 1);
    waitFrameStart();
    t0 = mt;
    applyStimulus(16'b1 << 10, 4);
    applyStimulus(16'h0, 5);
    checkOutput("bounce_pulses", dut_pulses - base, 1);
    checkOutput("bounce_latency", last_pulse_t - t0, 4 * FRAME);
    checkOutput("bounce_code", key_code, 4'h9);
    checkOutput("bounce_digits", {dig3, dig2, dig1, dig0}, 16'h3A79);

    // Two keys together, then clear in the accept cycle of "C"
    base = dut_pulses;
    applyStimulus(16'b11, 10);
    applyStimulus(16'h0, 5);
    checkOutput("multi_pulses", dut_pulses - base, 0);
    waitFrameStart();
    keys = 16'b1 << 11;
    repeat (4 * FRAME - 1) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checkOutput("clr_valid", key_valid, 1);
    checkOutput("clr_code", key_code, 4'hC);
    checkOutput("clr_digits", {dig3, dig2, dig1, dig0}, 16'h0000);
    waitFrames(1);
    applyStimulus(16'h0, 5);
    checkOutput("clr_pulses", dut_pulses - base, 1);

    // Reset while "F" is debouncing
    base = dut_pulses;
    applyStimulus(16'b1 << 13, 2);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    keys  = 16'h0;
    @(negedge clk);
    checkOutput("rst_code", key_code, 4'h0);
    checkOutput("rst_col", col, 4'b1110);
    checkOutput("rst_held", key_held, 0);
    reset = 1'b0;
    waitFrames(5);
    checkOutput("rst_pulses", dut_pulses - base, 0);
    checkOutput("rst_digits", {dig3, dig2, dig1, dig0}, 16'h0000);

    // Long hold of "4"
    base = dut_pulses;
    applyStimulus(16'b1 << 4, 12);
    applyStimulus(16'h0, 5);
`ifdef KYPD_AUTOREPEAT_EN
    checkOutput("hold_pulses", dut_pulses - base, 4);
    checkOutput("hold_digits", {dig3, dig2, dig1, dig0}, 16'h4444);
`else
    checkOutput("hold_pulses", dut_pulses - base, 1);
    checkOutput("hold_digits", {dig3, dig2, dig1, dig0}, 16'h0004);
`endif
    checkOutput("hold_code", key_code, 4'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
